// File: rtl/conversor_binario_bcd_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD converter.
interface conversor_binario_bcd_if #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
);
    logic                   start;
    logic [BIN_WIDTH-1:0]   bin;
    logic                   busy;
    logic                   done;
    logic [4*DIGITS-1:0]    bcd;
    logic                   overflow;

    modport master (output start, output bin, input busy, input done, input bcd, input overflow);
    modport slave  (input start, input bin, output busy, output done, output bcd, output overflow);
endinterface

// File: rtl/conversor_binario_bcd.sv
// Sequential double-dabble converter: one add-3 correction and one shift per clock,
// saturating to all nines when the value does not fit in DIGITS decimal digits.
module conversor_binario_bcd #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    conversor_binario_bcd_if.slave  bus
);
    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FINISH = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   shift_q, shift_d;
    logic [SW-1:0]          scratch_q, scratch_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lost_q, lost_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;
    logic [SW-1:0]          corr_s;

    function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Next-state, datapath and output computation
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        lost_d    = lost_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        corr_s    = add3(scratch_q);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    lost_d    = 1'b0;
                    cnt_d     = CW'(BIN_WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            SHIFT: begin
                // A set bit leaving the top digit means the value cannot be represented
                {scratch_d, shift_d} = {corr_s[SW-2:0], shift_q, 1'b0};
                lost_d = lost_q | corr_s[SW-1];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end else begin
                    state_d = SHIFT;
                end
            end
            FINISH: begin
                if ((scratch_q[SW-1 -: 4] != 4'd0) || lost_q) begin
                    ovf_d = 1'b1;
                    bcd_d = {DIGITS{4'h9}};
                end else begin
                    ovf_d = 1'b0;
                    bcd_d = scratch_q[4*DIGITS-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            lost_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            lost_q    <= lost_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Bench for the binary-to-BCD converter: an 8-bit and a 10-bit instance checked
// against an arithmetic decimal-digit model.
module tb_conversor_binario_bcd;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    conversor_binario_bcd_if #(.BIN_WIDTH(8),  .DIGITS(3)) ifa ();
    conversor_binario_bcd_if #(.BIN_WIDTH(10), .DIGITS(3)) ifb ();

    conversor_binario_bcd #(.BIN_WIDTH(8),  .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    conversor_binario_bcd #(.BIN_WIDTH(10), .DIGITS(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned bin;
        logic [11:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal digits by plain division; anything above 999 saturates
    task automatic ref_model(input int unsigned v, output logic [11:0] b, output logic o);
        if (v > 999) begin
            b = 12'h999;
            o = 1'b1;
        end else begin
            b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            o = 1'b0;
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? ifa.done : ifb.done;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic logic [11:0] get_bcd(input int sel);
        return (sel == 0) ? ifa.bcd : ifb.bcd;
    endfunction
    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? ifa.overflow : ifb.overflow;
    endfunction

    task automatic start_pulse(input int sel, input int unsigned v);
        if (sel == 0) begin
            ifa.start = 1'b1;
            ifa.bin   = 8'(v);
        end else begin
            ifb.start = 1'b1;
            ifb.bin   = 10'(v);
        end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic wait_done(input int sel, output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (!get_done(sel) && cyc < 60) begin
            if (get_busy(sel)) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic convert_check(input int sel, input int unsigned v, input string name);
        logic [11:0] eb;
        logic        eo;
        int          cyc;
        int          bc;
        ref_model(v, eb, eo);
        start_pulse(sel, v);
        wait_done(sel, cyc, bc);
        check({name, "_latency"}, 32'(cyc), (sel == 0) ? 32'd9 : 32'd11);
        check({name, "_bcd"}, 32'(get_bcd(sel)), 32'(eb));
        check({name, "_ovf"}, 32'(get_ovf(sel)), 32'(eo));
        @(negedge clk);
        check({name, "_done_clear"}, 32'(get_done(sel)), 32'd0);
    endtask

    initial begin
        vec_t        tbl[6];
        int          cyc;
        int          bc;
        int          pulses;
        logic [11:0] held;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.bin = '0;
        ifb.start = 1'b0; ifb.bin = '0;
        repeat (3) @(negedge clk);
        check("reset_bcd",  32'(ifa.bcd), 32'h0);
        check("reset_ovf",  32'(ifa.overflow), 32'd0);
        check("reset_busy", 32'(ifa.busy), 32'd0);
        check("reset_done", 32'(ifa.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // bin=0: busy for 9 cycles, done 9 cycles after start
        start_pulse(0, 0);
        wait_done(0, cyc, bc);
        check("zero_latency", 32'(cyc), 32'd9);
        check("zero_busy_cycles", 32'(bc), 32'd9);
        check("zero_bcd", 32'(ifa.bcd), 32'h000);
        check("zero_ovf", 32'(ifa.overflow), 32'd0);
        @(negedge clk);

        // bin=255: done is a single pulse and the result holds
        start_pulse(0, 255);
        wait_done(0, cyc, bc);
        check("max_bcd", 32'(ifa.bcd), 32'h255);
        check("max_ovf", 32'(ifa.overflow), 32'd0);
        @(negedge clk);
        check("max_done_one_cycle", 32'(ifa.done), 32'd0);
        repeat (20) @(negedge clk);
        check("max_bcd_held", 32'(ifa.bcd), 32'h255);

        // 99 then 100 with the second start in the done cycle
        start_pulse(0, 99);
        wait_done(0, cyc, bc);
        check("b2b_first_bcd", 32'(ifa.bcd), 32'h099);
        start_pulse(0, 100);
        wait_done(0, cyc, bc);
        check("b2b_spacing", 32'(cyc + 1), 32'd10);
        check("b2b_second_bcd", 32'(ifa.bcd), 32'h100);
        @(negedge clk);

        // start while busy is ignored
        start_pulse(0, 37);
        repeat (2) @(negedge clk);
        start_pulse(0, 200);
        wait_done(0, cyc, bc);
        check("busy_start_latency", 32'(cyc + 3), 32'd9);
        check("busy_start_bcd", 32'(ifa.bcd), 32'h037);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.done) pulses++;
        end
        check("busy_start_single_done", 32'(pulses), 32'd0);

        // reset mid-conversion
        start_pulse(0, 128);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(ifa.busy), 32'd0);
        check("midrst_bcd", 32'(ifa.bcd), 32'h000);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifa.done) pulses++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ifa.done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        convert_check(0, 128, "post_rst_128");

        // 10-bit instance: saturation boundaries
        convert_check(1, 1023, "w10_1023");
        convert_check(1, 999,  "w10_999");
        convert_check(1, 1000, "w10_1000");

        // table of small fixed vectors on the 8-bit instance
        tbl[0] = '{1,   12'h001, 1'b0};
        tbl[1] = '{9,   12'h009, 1'b0};
        tbl[2] = '{10,  12'h010, 1'b0};
        tbl[3] = '{200, 12'h200, 1'b0};
        tbl[4] = '{254, 12'h254, 1'b0};
        tbl[5] = '{5,   12'h005, 1'b0};
        foreach (tbl[i]) begin
            start_pulse(0, tbl[i].bin);
            wait_done(0, cyc, bc);
            check($sformatf("tbl_%0d_bcd", tbl[i].bin), 32'(ifa.bcd), 32'(tbl[i].exp_bcd));
            check($sformatf("tbl_%0d_ovf", tbl[i].bin), 32'(ifa.overflow), 32'(tbl[i].exp_ovf));
            @(negedge clk);
        end

        // random values against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            convert_check(0, $urandom_range(255, 0), $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            convert_check(1, $urandom_range(1023, 0), $sformatf("rnd10_%0d", i));
        end

        held = ifb.bcd;
        repeat (5) @(negedge clk);
        check("w10_hold", 32'(ifb.bcd), 32'(held));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
